// File: rtl/jpeg_fa_share_sched_if.sv
// rtl/jpeg_fa_share_sched_if.sv - requester/scheduler bundle for the shared full-adder scheduler
interface jpeg_fa_share_sched_if #(
    parameter int W    = 8,
    parameter int NREQ = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a;
    logic [NREQ*W-1:0] b;
    logic [NREQ-1:0]   cin;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IW-1:0]     done_id;
    logic [W-1:0]      sum;
    logic              cout;

    modport master (
        output req, a, b, cin,
        input  gnt, busy, done, done_id, sum, cout
    );

    modport slave (
        input  req, a, b, cin,
        output gnt, busy, done, done_id, sum, cout
    );
endinterface

// File: rtl/jpeg_fa_share_sched.sv
// rtl/jpeg_fa_share_sched.sv - round-robin time-sharing of one bit-serial full adder
module jpeg_fa_share_sched #(
    parameter int W    = 8,
    parameter int NREQ = 4
) (
    input logic                   clk,
    input logic                   rst,
    jpeg_fa_share_sched_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick;
    logic            found;
    logic [CW-1:0]   bitcnt;
    logic            carry;
    logic [W-1:0]    sh_a, sh_b, sh_s;
    logic [NREQ-1:0] gnt;
    logic            done;
    logic [IW-1:0]   done_id;
    logic [W-1:0]    sum;
    logic            cout;
    logic            fa_s, fa_c;

    assign fa_s = sh_a[0] ^ sh_b[0] ^ carry;
    assign fa_c = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

    // Rotating priority: first asserted req after the last granted index.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ADD;
            ADD:     if (bitcnt == CW'(W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= IW'(NREQ - 1);
            bitcnt  <= '0;
            carry   <= 1'b0;
            sh_a    <= '0;
            sh_b    <= '0;
            sh_s    <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    sh_a   <= bus.a[int'(pick)*W +: W];
                    sh_b   <= bus.b[int'(pick)*W +: W];
                    carry  <= bus.cin[pick];
                    gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    last   <= pick;
                    bitcnt <= '0;
                end
                ADD: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    carry  <= fa_c;
                    sh_s   <= {fa_s, sh_s[W-1:1]};
                    bitcnt <= bitcnt + 1'b1;
                    // Sum bit 0 entered first, so after W shifts it sits at the LSB.
                    if (bitcnt == CW'(W - 1)) begin
                        sum     <= {fa_s, sh_s[W-1:1]};
                        cout    <= fa_c;
                        done_id <= last;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done;
    assign bus.done_id = done_id;
    assign bus.sum     = sum;
    assign bus.cout    = cout;
endmodule

// File: tb/tb_jpeg_fa_share_sched.sv
// tb/tb_jpeg_fa_share_sched.sv - directed bench with a transaction-level reference model
module tb_jpeg_fa_share_sched;
    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    jpeg_fa_share_sched_if #(.W(W), .NREQ(NREQ)) bus ();
    jpeg_fa_share_sched #(.W(W), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an operation occupies W+1 cycles after the grant edge; the last is the done cycle.
    int              m_k;
    int              m_last;
    int              m_cur;
    logic [NREQ-1:0] m_gnt;
    logic            m_done;
    logic [IW-1:0]   m_id;
    logic [W:0]      m_res;
    logic [W-1:0]    m_sum;
    logic            m_cout;

    function automatic int next_grant(logic [NREQ-1:0] r, int lst);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (lst + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k <= 0; m_last <= NREQ - 1; m_cur <= 0; m_gnt <= '0; m_done <= 1'b0;
            m_id <= '0; m_res <= '0; m_sum <= '0; m_cout <= 1'b0;
        end else if (m_k == 0) begin
            int g;
            g = next_grant(bus.req, m_last);
            if (g >= 0) begin
                m_k    <= 1;
                m_cur  <= g;
                m_last <= g;
                m_gnt  <= NREQ'(1) << g;
                m_res  <= (W+1)'(int'(bus.a[g*W +: W]) + int'(bus.b[g*W +: W]) + int'(bus.cin[g]));
            end
        end else if (m_k == W) begin
            m_k    <= W + 1;
            m_done <= 1'b1;
            m_id   <= IW'(m_cur);
            m_sum  <= m_res[W-1:0];
            m_cout <= m_res[W];
        end else if (m_k == W + 1) begin
            m_k    <= 0;
            m_done <= 1'b0;
            m_gnt  <= '0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt",     32'(bus.gnt),     32'(m_gnt));
        chk("busy",    32'(bus.busy),    32'(m_k != 0));
        chk("done",    32'(bus.done),    32'(m_done));
        chk("done_id", 32'(bus.done_id), 32'(m_id));
        chk("sum",     32'(bus.sum),     32'(m_sum));
        chk("cout",    32'(bus.cout),    32'(m_cout));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (bus.done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within %0d cycles", n);
    endtask

    int n;

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.a = '0; bus.b = '0; bus.cin = '0;
        step(); step();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_done_id", 32'(bus.done_id), 0);
        rst = 1'b0;
        step();

        // Single request, no carry
        bus.a[2*W +: W] = 8'h5A; bus.b[2*W +: W] = 8'h33; bus.cin[2] = 1'b0;
        bus.req = 4'b0100;
        step();
        chk("t1_gnt", 32'(bus.gnt), 32'h4);
        wait_done(n);
        chk("t1_latency", 32'(n + 1), 9);
        chk("t1_sum", 32'(bus.sum), 32'h8D);
        chk("t1_cout", 32'(bus.cout), 0);
        chk("t1_id", 32'(bus.done_id), 2);
        bus.req = '0;

        // Carry propagation
        bus.a[1*W +: W] = 8'hFF; bus.b[1*W +: W] = 8'h01; bus.cin[1] = 1'b1;
        bus.req = 4'b0010;
        wait_done(n);
        chk("t2_sum", 32'(bus.sum), 32'h01);
        chk("t2_cout", 32'(bus.cout), 1);
        chk("t2_id", 32'(bus.done_id), 1);
        bus.req = '0;
        step();

        // Round robin from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.a[i*W +: W] = W'(8'h31 * i + 8'h17);
            bus.b[i*W +: W] = W'(8'hA5 - 8'h22 * i);
        end
        bus.cin = 4'b1010;
        bus.req = 4'b1111;
        wait_done(n);
        chk("rr_first_latency", 32'(n), 9);
        chk("rr_id0", 32'(bus.done_id), 0);
        for (int i = 1; i <= NREQ; i++) begin
            wait_done(n);
            chk("rr_spacing", 32'(n), 10);
            chk("rr_id", 32'(bus.done_id), 32'(i % NREQ));
        end
        bus.req = '0;
        step(); step();

        // Operand stability
        bus.a[0 +: W] = 8'h10; bus.b[0 +: W] = 8'h20; bus.cin[0] = 1'b0;
        bus.req = 4'b0001;
        step();
        n = 0;
        while (!bus.done && n < 40) begin
            bus.a[0 +: W] = W'($urandom);
            bus.cin[0] = 1'($urandom);
            step();
            n++;
        end
        chk("t4_done_seen", 32'(bus.done), 1);
        chk("t4_sum", 32'(bus.sum), 32'h30);
        chk("t4_cout", 32'(bus.cout), 0);
        bus.req = '0;
        bus.cin[0] = 1'b0;
        step();

        // Reset mid-operation at bitcnt 4
        bus.a[3*W +: W] = 8'h77; bus.b[3*W +: W] = 8'h11; bus.cin[3] = 1'b0;
        bus.req = 4'b1000;
        step();
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("t5_gnt", 32'(bus.gnt), 0);
        chk("t5_sum", 32'(bus.sum), 0);
        chk("t5_cout", 32'(bus.cout), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        bus.req = 4'b1001;
        step();
        rst = 1'b0;
        wait_done(n);
        chk("t5_first_id", 32'(bus.done_id), 0);
        bus.req = 4'b1000;
        wait_done(n);
        chk("t5_second_id", 32'(bus.done_id), 3);
        chk("t5_second_sum", 32'(bus.sum), 32'h88);
        bus.req = '0;
        step();

        // Req drop mid-operation
        bus.a[1*W +: W] = 8'hC3; bus.b[1*W +: W] = 8'h5E; bus.cin[1] = 1'b1;
        bus.req = 4'b1010;
        step(); step(); step();
        bus.req = 4'b1000;
        wait_done(n);
        chk("t6_id", 32'(bus.done_id), 1);
        chk("t6_sum", 32'(bus.sum), 32'h22);
        chk("t6_cout", 32'(bus.cout), 1);
        wait_done(n);
        chk("t6_next_id", 32'(bus.done_id), 3);
        bus.req = '0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jpeg_fa_share_sched.md
# jpeg_fa_share_sched

Round-robin scheduler that time-shares one full-adder slice with a carry register among several requesters in the JPEG timing datapath. Each requester wants an add of two W-bit operands plus a carry-in. Instead of instantiating W adder cells per requester, the block grants one requester at a time. It streams that requester's operands LSB-first through the shared FA (majority carry, XOR sum) and returns a W-bit sum and carry-out with a one-cycle done pulse.

## Interface
Parameters:
- W, 8, operand/sum width (≥2)
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request; must stay high until that requester sees done with done_id = its index
- a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- b  in  NREQ*W  operand B, same packing
- cin  in  NREQ  per-requester carry-in
- gnt  out  NREQ  one-hot grant, held for the whole operation
- busy  out  1  high in ADD and DONE
- done  out  1  one-cycle pulse, result valid
- done_id  out  clog2(NREQ)  index of completed requester, valid with done, held afterwards
- sum  out  W  result, held until the next done
- cout  out  1  final carry, held until the next done

## Operation
FSM states: IDLE, ADD, DONE.

- **IDLE**
  - Search req starting at (last+1) mod NREQ, wrapping.
  - If a request is found, on the next edge:
    - latch that requester's a, b into shift registers and cin into the carry flop;
    - set gnt one-hot, last=index, bitcnt=0, state=ADD.
  - No request: stay in IDLE, all outputs hold.
- **ADD** (exactly W cycles)
  - Each edge: s = a0^b0^c; c = MAJ(a0,b0,c); shift A and B right; shift s into the sum shift register MSB-first so bit 0 ends at LSB.
  - bitcnt increments each edge.
  - On the edge where bitcnt==W-1: load sum, cout and done_id; set done=1; state=DONE.
- **DONE** (one cycle)
  - Next edge: done=0, gnt=0, state=IDLE.
  - Arbitration resumes in IDLE, so there is always one IDLE cycle between operations.
- **Arbitration and inputs**
  - Operands are sampled only at grant. Changes to a, b or cin during ADD are ignored.
  - Deassertion of req during ADD or DONE is ignored; the operation completes and done still pulses.
  - New req assertions during ADD or DONE are held off until the next IDLE.
  - Fairness: a continuously requesting requester waits at most (NREQ-1) operations.
- **Arithmetic:** {cout,sum} = a + b + cin, modulo 2^(W+1). No overflow flag.

## Timing
- **Reset values** (immediate, asynchronous): state=IDLE, gnt=0, busy=0, done=0, done_id=0, sum=0, cout=0, bitcnt=0, carry=0, last=NREQ-1 (requester 0 has first priority).
- **Latency:** req seen in IDLE at cycle t gives:
  - gnt high from t+1;
  - busy high t+1..t+W+1;
  - done high in cycle t+W+1 only;
  - gnt low at t+W+2.
- **Throughput:** one operation per W+2 cycles under continuous demand.
- **Reset mid-operation:** the operation is aborted with no done pulse. After rst deasserts, arbitration restarts from requester 0. sum and cout read 0, not the partial result.
- **Simultaneous events:** a new grant is never issued in the same cycle done is high. A requester whose req drops in the same cycle it would be granted in IDLE is not granted, because the decision uses the req value at the edge.

## Test plan
- **Single request, no carry:** W=8, req=0100, a[2]=0x5A, b[2]=0x33, cin[2]=0.
  - Expect gnt=0100 one cycle after req.
  - Expect done 9 cycles after req sampled, with sum=0x8D, cout=0, done_id=2.
- **Carry propagation:** req[1]; a=0xFF, b=0x01, cin=1. Expect sum=0x01, cout=1.
- **Round-robin:** all four req held high from reset, distinct operands.
  - Expect grants 0,1,2,3,0 at 10-cycle spacing.
  - Each done_id matches its grant and each sum is correct.
- **Operand stability:** change a[0] every cycle during ADD. Expect sum to equal the add of the values latched at grant.
- **Reset mid-op:** assert rst while bitcnt=4 on a req[3] operation.
  - Expect no done, and gnt, sum and cout immediately 0.
  - With req[0] and req[3] both held after rst deasserts, requester 0 is granted first.
- **Req drop mid-op:** drop req[1] during ADD. Expect done with done_id=1 and the correct sum, then the next requester in round-robin order is granted.
